// File: rtl/block_levelshift_zigzag_engine.sv
// ============================================================================
// Module   : block_levelshift_zigzag_engine
// Level-shifts an 8x8 pixel block by -128 and rewrites it in JPEG zigzag order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module block_levelshift_zigzag_engine #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_ADDR_WIDTH   = 4,
  parameter int C_NUM_WORDS        = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd_en,
  output logic [C_MEM_ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rd_data,
  output logic                          mem_wr_en,
  output logic [C_MEM_ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]                    mem_wr_strb
);

  localparam int c_BYTES_PER_WORD = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [C_MEM_ADDR_WIDTH-1:0] r_cnt;
  logic [C_MEM_ADDR_WIDTH-1:0] w_cnt_next;
  logic                        w_last;
  logic                        r_cap_en;
  logic [C_MEM_ADDR_WIDTH-1:0] r_cap_addr;
  logic [7:0]                  r_buf [0:63];
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_word;

  function automatic logic [5:0] zz_index(input logic [5:0] i);
    logic [5:0] z;
    case (i)
      6'd0:  z = 6'd0;  6'd1:  z = 6'd1;  6'd2:  z = 6'd8;  6'd3:  z = 6'd16;
      6'd4:  z = 6'd9;  6'd5:  z = 6'd2;  6'd6:  z = 6'd3;  6'd7:  z = 6'd10;
      6'd8:  z = 6'd17; 6'd9:  z = 6'd24; 6'd10: z = 6'd32; 6'd11: z = 6'd25;
      6'd12: z = 6'd18; 6'd13: z = 6'd11; 6'd14: z = 6'd4;  6'd15: z = 6'd5;
      6'd16: z = 6'd12; 6'd17: z = 6'd19; 6'd18: z = 6'd26; 6'd19: z = 6'd33;
      6'd20: z = 6'd40; 6'd21: z = 6'd48; 6'd22: z = 6'd41; 6'd23: z = 6'd34;
      6'd24: z = 6'd27; 6'd25: z = 6'd20; 6'd26: z = 6'd13; 6'd27: z = 6'd6;
      6'd28: z = 6'd7;  6'd29: z = 6'd14; 6'd30: z = 6'd21; 6'd31: z = 6'd28;
      6'd32: z = 6'd35; 6'd33: z = 6'd42; 6'd34: z = 6'd49; 6'd35: z = 6'd56;
      6'd36: z = 6'd57; 6'd37: z = 6'd50; 6'd38: z = 6'd43; 6'd39: z = 6'd36;
      6'd40: z = 6'd29; 6'd41: z = 6'd22; 6'd42: z = 6'd15; 6'd43: z = 6'd23;
      6'd44: z = 6'd30; 6'd45: z = 6'd37; 6'd46: z = 6'd44; 6'd47: z = 6'd51;
      6'd48: z = 6'd58; 6'd49: z = 6'd59; 6'd50: z = 6'd52; 6'd51: z = 6'd45;
      6'd52: z = 6'd38; 6'd53: z = 6'd31; 6'd54: z = 6'd39; 6'd55: z = 6'd46;
      6'd56: z = 6'd53; 6'd57: z = 6'd60; 6'd58: z = 6'd61; 6'd59: z = 6'd54;
      6'd60: z = 6'd47; 6'd61: z = 6'd55; 6'd62: z = 6'd62; default: z = 6'd63;
    endcase
    return z;
  endfunction

  assign w_last = (r_cnt == C_MEM_ADDR_WIDTH'(C_NUM_WORDS - 1));

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_READ;
          w_cnt_next   = '0;
        end
      end
      ST_READ: begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_next = ST_WRITE;
        w_cnt_next   = '0;
      end
      ST_WRITE: begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Word 0 is prepared before the final read word lands; its sources all sit in words 0..4.
  always_comb begin
    w_wr_word = '0;
    for (int j = 0; j < c_BYTES_PER_WORD; j++) begin
      w_wr_word[8*j +: 8] = r_buf[zz_index({w_cnt_next, 2'(j)})] ^ 8'h80;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_strb <= 4'h0;
      r_cap_en    <= 1'b0;
      r_cap_addr  <= '0;
    end else begin
      busy        <= (w_state_next == ST_READ) || (w_state_next == ST_DRAIN) ||
                     (w_state_next == ST_WRITE);
      done        <= (w_state_next == ST_DONE);
      mem_rd_en   <= (w_state_next == ST_READ);
      mem_rd_addr <= (w_state_next == ST_READ) ? w_cnt_next : '0;
      mem_wr_en   <= (w_state_next == ST_WRITE);
      mem_wr_addr <= (w_state_next == ST_WRITE) ? w_cnt_next : '0;
      mem_wr_data <= (w_state_next == ST_WRITE) ? w_wr_word : '0;
      mem_wr_strb <= (w_state_next == ST_WRITE) ? 4'hF : 4'h0;
      r_cap_en    <= mem_rd_en;
      r_cap_addr  <= mem_rd_addr;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (r_cap_en) begin
      for (int j = 0; j < c_BYTES_PER_WORD; j++) begin
        r_buf[{r_cap_addr, 2'(j)}] <= mem_rd_data[8*j +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block_levelshift_zigzag_engine.sv
// ============================================================================
// Module   : tb_block_levelshift_zigzag_engine
// Scoreboarded bench: buffer model, cycle-accurate control checks, write monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_block_levelshift_zigzag_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;

  logic [31:0] mem      [16];
  logic [31:0] load_val [16];
  logic        load_req;
  logic [31:0] exp_w    [16];
  logic [35:0] sb_q     [$];
  int          n_checks;
  int          n_fail;

  logic [31:0] ramp_out [16] = '{32'h90888180, 32'h8A838289, 32'h99A09891, 32'h85848B92,
                                 32'hA19A938C, 32'hA2A9B0A8, 32'h868D949B, 32'h9C958E87,
                                 32'hB8B1AAA3, 32'hA4ABB2B9, 32'h978F969D, 32'hB3ACA59E,
                                 32'hADB4BBBA, 32'hAEA79FA6, 32'hB6BDBCB5, 32'hBFBEB7AF};

  block_levelshift_zigzag_engine #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_MEM_ADDR_WIDTH(4),
    .C_NUM_WORDS(16)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Block buffer model: one-cycle read latency, bench-side bulk load.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (load_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= load_val[i];
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write @%0t: addr %0h data %0h, expected none",
                 $time, mem_wr_addr, mem_wr_data);
      end else begin
        logic [35:0] e;
        e = sb_q.pop_front();
        check("wr_addr_data_strb", {24'h0, mem_wr_addr, mem_wr_data, mem_wr_strb},
              {24'h0, e, 4'hF});
      end
    end
  end

  function automatic logic [7:0] exp_ctrl(input int n);
    logic b, d, r, w;
    b = (n >= 1) && (n <= 33);
    d = (n >= 34);
    r = (n >= 1) && (n <= 16);
    w = (n >= 18) && (n <= 33);
    return {b, d, r, w, (w ? 4'hF : 4'h0)};
  endfunction

  task automatic load(input int kind, input logic [31:0] v);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       load_val[i] = v;
        1:       load_val[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        default: load_val[i] = (i == 0) ? 32'hFF807F00 : 32'h0;
      endcase
    end
    @(posedge clk);
    #1 load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic run_block(input int ncyc, input int x1, input int x2, input int abort_at);
    for (int i = 0; i < 16; i++) sb_q.push_back({4'(i), exp_w[i]});
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      check($sformatf("ctrl_c%0d", n),
            {56'h0, busy, done, mem_rd_en, mem_wr_en, mem_wr_strb}, {56'h0, exp_ctrl(n)});
      if (mem_rd_en) check($sformatf("rd_addr_c%0d", n), {60'h0, mem_rd_addr}, 64'(n - 1));
      start = (n == x1) || (n == x2);
      if (n == abort_at) begin
        start = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_abort", {61'h0, busy, mem_wr_en, done}, 64'h0);
        sb_q.delete();
        break;
      end
    end
    start = 1'b0;
    if (abort_at == 0) check("all_writes_seen", 64'(sb_q.size()), 64'h0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    load_req = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
                          mem_wr_data, mem_wr_strb}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All 0x01 -> 0x81; run to C39 so the next start lands at C40.
    load(0, 32'h01010101);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h81818181;
    run_block(39, 0, 0, 0);

    // Restart from DONE: the block now holds 0x81, which shifts back to 0x01.
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h01010101;
    run_block(36, 0, 0, 0);
    for (int i = 0; i < 16; i++) check($sformatf("mem_after_rerun_w%0d", i), 64'(mem[i]),
                                       64'h01010101);

    // Ramp with stray starts while busy.
    load(1, 32'h0);
    for (int i = 0; i < 16; i++) exp_w[i] = ramp_out[i];
    run_block(36, 5, 20, 0);

    // Boundary pixel values in word 0.
    load(2, 32'h0);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h80808080;
    exp_w[0] = 32'h8080FF80;
    exp_w[1] = 32'h807F0080;
    run_block(36, 0, 0, 0);

    // Reset mid-write, then start held together with reset.
    load(1, 32'h0);
    for (int i = 0; i < 16; i++) exp_w[i] = ramp_out[i];
    run_block(36, 0, 0, 20);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("idle_after_reset_%0d", n), {61'h0, busy, done, mem_rd_en}, 64'h0);
    end
    load(1, 32'h0);
    run_block(36, 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
